// File: rtl/cavlc_blk_scheduler.sv
// cavlc_blk_scheduler: issues 4x4 luma block coordinates in macroblock order,
// bounds blocks in flight with credits, counts completions, flags frame end.
// Ports: clk, rst (async active-low), h264_reset (sync clear), start,
//   frame_width/height (latched at start), coord_* (issue handshake),
//   enc_* (completion handshake), inflight, busy, frame_done, dim_err,
//   order_err.
// Optional macro CAVLC_SCHED_ORDER_CHECK_EN: FIFO of issued coordinates
//   compared against enc_x/enc_y; otherwise order_err is tied 0.
module cavlc_blk_scheduler #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h264_reset,
    input  logic        start,
    input  logic [11:0] frame_width,
    input  logic [11:0] frame_height,
    output logic        coord_valid,
    input  logic        coord_ready,
    output logic [10:0] coord_x,
    output logic [10:0] coord_y,
    input  logic        enc_valid,
    input  logic        enc_ready,
    input  logic [10:0] enc_x,
    input  logic [10:0] enc_y,
    output logic [3:0]  inflight,
    output logic        busy,
    output logic        frame_done,
    output logic        dim_err,
    output logic        order_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       w_mb, h_mb, mbx, mby, mbx_nxt, mby_nxt;
    logic [3:0]       blk, blk_nxt;
    logic [3:0]       infl_q;
    logic [CNT_W-1:0] total, done_cnt;
    logic [15:0]      mb_prod;
    logic [11:0]      x_nxt, y_nxt;
    logic             dims_ok, start_ok, accept, comp, last_blk;

    assign dims_ok  = (frame_width != 12'd0) && (frame_width[3:0] == 4'd0) &&
                      (frame_height != 12'd0) && (frame_height[3:0] == 4'd0);
    assign start_ok = (state == S_IDLE) && start && dims_ok;
    assign accept   = coord_valid && coord_ready;
    // Completions only count while a frame is active and a credit is held.
    assign comp     = enc_valid && enc_ready && (infl_q != 4'd0) &&
                      (state == S_ISSUE || state == S_DRAIN);
    assign last_blk = (blk == 4'hf) && (mbx == w_mb - 8'd1) &&
                      (mby == h_mb - 8'd1);
    assign mb_prod  = 16'(frame_width[11:4]) * 16'(frame_height[11:4]);

    // Next block in macroblock-raster / blkIdx order.
    always_comb begin
        blk_nxt = blk + 4'd1;
        mbx_nxt = mbx;
        mby_nxt = mby;
        if (blk == 4'hf) begin
            if (mbx == w_mb - 8'd1) begin
                mbx_nxt = 8'd0;
                mby_nxt = mby + 8'd1;
            end else begin
                mbx_nxt = mbx + 8'd1;
            end
        end
        x_nxt = {mbx_nxt, 4'b0} + {8'b0, blk_nxt[2], blk_nxt[0], 2'b0};
        y_nxt = {mby_nxt, 4'b0} + {8'b0, blk_nxt[3], blk_nxt[1], 2'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            state <= S_IDLE;
        else if (h264_reset) state <= S_IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_nxt = S_ISSUE;
            S_ISSUE: if (accept && last_blk) state_nxt = S_DRAIN;
            S_DRAIN: if (done_cnt == total) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        coord_valid = (state == S_ISSUE) && (infl_q < 4'(MAX_INFLIGHT));
        busy        = (state != S_IDLE);
        frame_done  = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_mb <= '0; h_mb <= '0; mbx <= '0; mby <= '0; blk <= '0;
            coord_x <= '0; coord_y <= '0; infl_q <= '0;
            total <= '0; done_cnt <= '0; dim_err <= 1'b0;
        end else if (h264_reset) begin
            w_mb <= '0; h_mb <= '0; mbx <= '0; mby <= '0; blk <= '0;
            coord_x <= '0; coord_y <= '0; infl_q <= '0;
            total <= '0; done_cnt <= '0; dim_err <= 1'b0;
        end else if (start_ok) begin
            w_mb     <= frame_width[11:4];
            h_mb     <= frame_height[11:4];
            total    <= CNT_W'({mb_prod, 4'b0000});
            mbx      <= '0;
            mby      <= '0;
            blk      <= '0;
            coord_x  <= '0;
            coord_y  <= '0;
            infl_q   <= '0;
            done_cnt <= '0;
        end else begin
            if (state == S_IDLE && start && !dims_ok) dim_err <= 1'b1;
            if (accept) begin
                blk     <= blk_nxt;
                mbx     <= mbx_nxt;
                mby     <= mby_nxt;
                coord_x <= x_nxt[10:0];
                coord_y <= y_nxt[10:0];
            end
            infl_q   <= infl_q + 4'(accept) - 4'(comp);
            done_cnt <= done_cnt + CNT_W'(comp);
        end
    end

    assign inflight = infl_q;

    wire unused_msb = x_nxt[11] ^ y_nxt[11];

`ifdef CAVLC_SCHED_ORDER_CHECK_EN
    logic [21:0] fifo_mem [MAX_INFLIGHT];
    logic [3:0]  wr_ptr, rd_ptr;
    logic        enc_hs;

    assign enc_hs = enc_valid && enc_ready &&
                    (state == S_ISSUE || state == S_DRAIN);

    function automatic logic [3:0] ptr_inc(input logic [3:0] p);
        return (p == 4'(MAX_INFLIGHT - 1)) ? 4'd0 : p + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= {coord_x, coord_y};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0; rd_ptr <= '0; order_err <= 1'b0;
        end else if (h264_reset) begin
            wr_ptr <= '0; rd_ptr <= '0; order_err <= 1'b0;
        end else if (start_ok) begin
            wr_ptr <= '0; rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= ptr_inc(wr_ptr);
            if (comp) begin
                rd_ptr <= ptr_inc(rd_ptr);
                if (fifo_mem[rd_ptr] != {enc_x, enc_y}) order_err <= 1'b1;
            end
            // A completion with no credit outstanding is out of order too.
            if (enc_hs && infl_q == 4'd0) order_err <= 1'b1;
        end
    end
`else
    assign order_err = 1'b0;
    wire unused_enc = ^{enc_x, enc_y};
`endif

endmodule
